// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM state definitions for the round-robin ALU scheduler.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_ABS = 2'd3;

  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_S = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index strictly after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_valid
);

  localparam int unsigned IW = $clog2(N);

  int unsigned       sum;
  logic [IW-1:0]     idx;

  // Offsets 1..N visit every index once, ending on ptr itself.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      sum = 32'(ptr) + off;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IW'(sum);
      if (!any_valid && valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external ALU between NUM_REQ requesters,
// returning each result on a single tagged valid/ready response channel.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*2-1:0]       req_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [1:0]                 alu_op,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic [3:0]                 alu_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_result,
  output logic [3:0]                 rsp_flags,
  output logic                       busy
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam logic [1:0]  LAT_INIT = 2'(ALU_LAT);

  sched_state_t      state_q;
  logic [IDW-1:0]    ptr_q;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [IDW-1:0]    id_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        flg_q;
  logic              vld_q;

  logic [IDW-1:0]    grant;
  logic              any_valid;

  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];
  logic [1:0]        op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_op[g*2 +: 2];
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .valid    (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .any_valid(any_valid)
  );

  // Ready is offered only to the arbitration winner, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && any_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q     <= a_arr[grant];
            b_q     <= b_arr[grant];
            op_q    <= op_arr[grant];
            id_q    <= grant;
            ptr_q   <= grant;
            cnt_q   <= LAT_INIT;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Capture only once the ALU has had ALU_LAT extra cycles to settle.
          if (cnt_q == '0) begin
            res_q   <= alu_result;
            flg_q   <= alu_flags;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = vld_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench: two schedulers (ALU_LAT=1 and ALU_LAT=3) each driving a delayed ALU model.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic [3:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q1[$];
  exp_t q3[$];

  // Bench-side ALU reference: {C,V,Z,S,result}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_ADC: begin s = {1'b0, a} + {1'b0, b} + 9'd1; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      default: begin r = a[7] ? (~a + 8'd1) : a; v = (a == 8'h80); end
    endcase
    return {c, v, (r == 8'h00), r[7], r};
  endfunction

  logic [3:0]  req_valid1 = '0, req_ready1;
  logic [31:0] req_a1 = '0, req_b1 = '0;
  logic [7:0]  req_op1 = '0;
  logic [7:0]  alu_a1, alu_b1, alu_result1, rsp_result1;
  logic [1:0]  alu_op1, rsp_id1;
  logic [3:0]  alu_flags1, rsp_flags1;
  logic        rsp_valid1, rsp_ready1 = 1'b1, busy1;

  logic [3:0]  req_valid3 = '0, req_ready3;
  logic [31:0] req_a3 = '0, req_b3 = '0;
  logic [7:0]  req_op3 = '0;
  logic [7:0]  alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [1:0]  alu_op3, rsp_id3;
  logic [3:0]  alu_flags3, rsp_flags3;
  logic        rsp_valid3, rsp_ready3 = 1'b1, busy3;

  alu_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_op(req_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_result(alu_result1), .alu_flags(alu_flags1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
    .rsp_result(rsp_result1), .rsp_flags(rsp_flags1), .busy(busy1)
  );

  alu_rr_scheduler #(.NUM_REQ(4), .DATA_W(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_result3), .alu_flags(alu_flags3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_flags(rsp_flags3), .busy(busy3)
  );

  // ALU models: outputs follow operand changes after 1 and 3 clock edges.
  logic [11:0] m1_q;
  logic [11:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= alu_ref(alu_a1, alu_b1, alu_op1);
    m3_q[0] <= alu_ref(alu_a3, alu_b3, alu_op3);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign alu_result1 = m1_q[7:0];
  assign alu_flags1  = m1_q[11:8];
  assign alu_result3 = m3_q[2][7:0];
  assign alu_flags3  = m3_q[2][11:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put1(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a1[i*8 +: 8] = a;
    req_b1[i*8 +: 8] = b;
    req_op1[i*2 +: 2] = op;
    req_valid1[i] = 1'b1;
  endtask

  task automatic wait_ready1(output int t);
    t = 0;
    #1;
    while (req_ready1 == '0 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  task automatic drain(input bool_sel);
  endtask

  task automatic drain1();
    int t = 0;
    while (q1.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain1", q1.size(), 0);
  endtask

  // Monitors: pop and compare whenever a response handshake is presented.
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp1_unexpected: got id=%0d result=0x%0h, expected no response", rsp_id1, rsp_result1);
      end else begin
        e = q1.pop_front();
        check("rsp1_id", rsp_id1, e.id);
        check("rsp1_result", rsp_result1, e.res);
        check("rsp1_flags", rsp_flags1, e.flg);
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && rsp_valid3 && rsp_ready3) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp3_unexpected: got id=%0d result=0x%0h, expected no response", rsp_id3, rsp_result3);
      end else begin
        e = q3.pop_front();
        check("rsp3_id", rsp_id3, e.id);
        check("rsp3_result", rsp_result3, e.res);
        check("rsp3_flags", rsp_flags3, e.flg);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] va [4];
  logic [7:0] vb [4];
  logic [1:0] vop [4];
  logic [7:0] vres [4];
  logic [3:0] vflg [4];
  int ord [5];

  initial begin
    int t, last, id;
    va   = '{8'hFF, 8'h05, 8'h3F, 8'h80};
    vb   = '{8'h01, 8'h07, 8'h40, 8'h00};
    vop  = '{OP_ADD, OP_SUB, OP_ADC, OP_ABS};
    vres = '{8'h00, 8'hFE, 8'h80, 8'h80};
    vflg = '{4'b1010, 4'b1001, 4'b0101, 4'b0101};
    ord  = '{0, 1, 2, 3, 0};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_req_ready", req_ready1, 0);
    check("rst_alu_a", alu_a1, 0);
    check("rst_rsp_id", rsp_id1, 0);
    check("rst_rsp_result", rsp_result1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Strict rotation with all requesters valid.
    @(negedge clk);
    for (int i = 0; i < 4; i++) put1(i, va[i], vb[i], vop[i]);
    last = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      wait_ready1(t);
      id = ord[k];
      check("rot_ready", req_ready1, 32'(1) << id);
      if (k > 0) check("rot_gap", cyc - last, 4);
      last = cyc;
      q1.push_back({2'(id), vres[id], vflg[id]});
    end
    @(negedge clk);
    req_valid1 = '0;
    drain1();

    // Single request, exact latency.
    @(negedge clk);
    put1(2, 8'h7F, 8'h01, OP_ADD);
    #1;
    check("single_ready", req_ready1, 4'b0100);
    q1.push_back({2'd2, 8'h80, 4'b0101});
    @(negedge clk);
    req_valid1 = '0;
    #1;
    check("single_alu_a", alu_a1, 8'h7F);
    check("single_alu_b", alu_b1, 8'h01);
    check("single_alu_op", alu_op1, OP_ADD);
    check("single_busy", busy1, 1);
    check("single_vld_c1", rsp_valid1, 0);
    @(negedge clk); #1;
    check("single_vld_c2", rsp_valid1, 0);
    @(negedge clk); #1;
    check("single_vld_c3", rsp_valid1, 1);
    @(negedge clk); #1;
    check("single_idle_c4", busy1, 0);
    drain1();

    // Backpressure: response held, no accept while in RESP.
    @(negedge clk);
    rsp_ready1 = 1'b0;
    put1(1, 8'h05, 8'h07, OP_SUB);
    #1;
    check("bp_ready", req_ready1, 4'b0010);
    q1.push_back({2'd1, 8'hFE, 4'b1001});
    @(negedge clk);
    req_valid1 = '0;
    t = 0;
    #1;
    while (!rsp_valid1 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("bp_wait_valid", rsp_valid1, 1);
    put1(3, 8'h80, 8'h00, OP_ABS);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold_valid", rsp_valid1, 1);
      check("bp_hold_id", rsp_id1, 1);
      check("bp_hold_result", rsp_result1, 8'hFE);
      check("bp_hold_flags", rsp_flags1, 4'b1001);
      check("bp_hold_ready", req_ready1, 0);
      @(negedge clk);
    end
    rsp_ready1 = 1'b1;
    q1.push_back({2'd3, 8'h80, 4'b0101});
    @(negedge clk); #1;
    check("bp_release_idle", busy1, 0);
    check("bp_release_ready", req_ready1, 4'b1000);
    @(negedge clk);
    req_valid1 = '0;
    drain1();

    // ALU_LAT=3: capture must wait for settled output.
    @(negedge clk);
    req_a3[7:0] = 8'h10;
    req_b3[7:0] = 8'h05;
    req_op3[1:0] = OP_SUB;
    req_valid3[0] = 1'b1;
    #1;
    check("lat3_ready", req_ready3, 4'b0001);
    q3.push_back({2'd0, 8'h0B, 4'b0000});
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req_valid3 = '0;
      #1;
      check("lat3_valid_timing", rsp_valid3, (c == 5) ? 1 : 0);
    end
    t = 0;
    while (q3.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain3", q3.size(), 0);

    // Asynchronous reset while in EXEC drops the request.
    @(negedge clk);
    put1(2, 8'h01, 8'h01, OP_ADD);
    #1;
    check("rstx_ready", req_ready1, 4'b0100);
    @(negedge clk);
    req_valid1 = '0;
    #1;
    check("rstx_busy_exec", busy1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstx_busy", busy1, 0);
    check("rstx_rsp_valid", rsp_valid1, 0);
    check("rstx_req_ready", req_ready1, 0);
    check("rstx_alu", {alu_a1, alu_b1, 6'd0, alu_op1}, 0);
    check("rstx_rsp", {rsp_id1, rsp_result1, rsp_flags1}, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    put1(0, 8'hFF, 8'h01, OP_ADD);
    put1(3, 8'h80, 8'h00, OP_ABS);
    #1;
    check("rstx_first_grant", req_ready1, 4'b0001);
    q1.push_back({2'd0, 8'h00, 4'b1010});
    @(negedge clk);
    req_valid1[0] = 1'b0;
    wait_ready1(t);
    check("rstx_second_grant", req_ready1, 4'b1000);
    q1.push_back({2'd3, 8'h80, 4'b0101});
    @(negedge clk);
    req_valid1 = '0;
    drain1();

    // Requester 1 withdraws while requester 0 is served.
    @(negedge clk);
    put1(0, 8'h3F, 8'h40, OP_ADC);
    put1(1, 8'h05, 8'h07, OP_SUB);
    #1;
    check("wd_ready", req_ready1, 4'b0001);
    q1.push_back({2'd0, 8'h80, 4'b0101});
    @(negedge clk);
    req_valid1 = '0;
    t = 0;
    #1;
    while (busy1 && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    check("wd_busy_fall", busy1, 0);
    check("wd_served", q1.size(), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("wd_no_rsp", rsp_valid1, 0);
      check("wd_no_ready", req_ready1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
